// File: rtl/swi_debouncer_if.sv
// Switch conditioning bundle: raw switch levels in, debounced levels and edge pulses out.
interface swi_debouncer_if #(
  parameter int NBITS = 8
);
  logic [NBITS-1:0] swi_raw;
  logic [NBITS-1:0] swi_stable;
  logic [NBITS-1:0] swi_rise;
  logic [NBITS-1:0] swi_fall;
  logic             swi_changed;

  modport master (
    output swi_raw,
    input  swi_stable,
    input  swi_rise,
    input  swi_fall,
    input  swi_changed
  );

  modport slave (
    input  swi_raw,
    output swi_stable,
    output swi_rise,
    output swi_fall,
    output swi_changed
  );
endinterface

// File: rtl/swi_debouncer.sv
// Per-bit two-flop synchroniser plus stability counter; emits clean levels and one-cycle rise/fall pulses.
//
// state      | meaning
// IDLE       | cnt == 0, synchronised input agrees with stable level
// QUALIFYING | cnt > 0, input has differed from stable level for cnt cycles
module swi_debouncer #(
  parameter  int NBITS           = 8,
  parameter  int DEBOUNCE_CYCLES = 16,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic           clk_2,
  input  logic           reset,
  swi_debouncer_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NBITS-1:0] s1;
  logic [NBITS-1:0] s2;
  logic [NBITS-1:0] stable_q;
  logic [NBITS-1:0] rise_q;
  logic [NBITS-1:0] fall_q;
  logic             changed_q;
  logic [CNT_W-1:0] cnt_q [NBITS];

  logic [NBITS-1:0] stable_d;
  logic [NBITS-1:0] rise_d;
  logic [NBITS-1:0] fall_d;
  logic             changed_d;
  logic [CNT_W-1:0] cnt_d [NBITS];

  always_ff @(posedge clk_2) begin
    if (reset) begin
      s1        <= '0;
      s2        <= '0;
      stable_q  <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < NBITS; i++) cnt_q[i] <= '0;
    end else begin
      s1        <= bus.swi_raw;
      s2        <= s1;
      stable_q  <= stable_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      for (int i = 0; i < NBITS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Any return to the stable value discards the partial count, so short glitches never qualify.
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < NBITS; i++) begin
      cnt_d[i] = '0;
      if (s2[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = s2[i];
        rise_d[i]   = s2[i];
        fall_d[i]   = ~s2[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  always_comb begin
    bus.swi_stable  = stable_q;
    bus.swi_rise    = rise_q;
    bus.swi_fall    = fall_q;
    bus.swi_changed = changed_q;
  end

endmodule

// File: tb/tb_swi_debouncer.sv
// Directed bench for swi_debouncer with DEBOUNCE_CYCLES=4: reset, step, bounce, glitch, simultaneous, reset mid-count.
module tb_swi_debouncer;

  logic clk_2 = 1'b0;
  logic reset = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  swi_debouncer_if #(.NBITS(8)) bus ();

  swi_debouncer #(.NBITS(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rise"}, 32'(bus.swi_rise), 32'h0);
    chk({tag, "_fall"}, 32'(bus.swi_fall), 32'h0);
    chk({tag, "_chg"},  32'(bus.swi_changed), 32'h0);
  endtask

  // Input already applied; 5 quiet edges, pulse on the 6th, quiet again on the 7th.
  task automatic settle(input string tag, input logic [7:0] old_stable, input logic [7:0] new_stable,
                        input logic [7:0] exp_rise, input logic [7:0] exp_fall);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_quiet({tag, "_wait"});
      chk({tag, "_hold"}, 32'(bus.swi_stable), 32'(old_stable));
    end
    tick();
    chk({tag, "_stable"}, 32'(bus.swi_stable), 32'(new_stable));
    chk({tag, "_rise"},   32'(bus.swi_rise), 32'(exp_rise));
    chk({tag, "_fall"},   32'(bus.swi_fall), 32'(exp_fall));
    chk({tag, "_chg"},    32'(bus.swi_changed), 32'(|(exp_rise | exp_fall)));
    tick();
    chk_quiet({tag, "_after"});
    chk({tag, "_keep"}, 32'(bus.swi_stable), 32'(new_stable));
  endtask

  initial begin
    logic [4:0] bounce;
    bounce = 5'b01101;  // bit i is cycle i: 1,0,1,1,0

    // Reset held two cycles with all switches on.
    bus.swi_raw = 8'hFF;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_stable", 32'(bus.swi_stable), 32'h0);
      chk_quiet("rst");
    end
    reset = 1'b0;
    settle("rst_rel", 8'h00, 8'hFF, 8'hFF, 8'h00);

    // All off.
    bus.swi_raw = 8'h00;
    settle("all_off", 8'hFF, 8'h00, 8'h00, 8'hFF);

    // Clean step on bit 3.
    bus.swi_raw = 8'h08;
    settle("step3", 8'h00, 8'h08, 8'h08, 8'h00);

    // Bounce on bit 1, then steady high.
    for (int i = 0; i < 5; i++) begin
      bus.swi_raw = {6'b000010, bounce[i], 1'b0};
      tick();
      chk_quiet("bounce");
      chk("bounce_hold", 32'(bus.swi_stable), 32'h08);
    end
    bus.swi_raw = 8'h0A;
    settle("bounce1", 8'h08, 8'h0A, 8'h02, 8'h00);

    // Set bit 5, then a 3-cycle low glitch must be rejected.
    bus.swi_raw = 8'h2A;
    settle("set5", 8'h0A, 8'h2A, 8'h20, 8'h00);
    bus.swi_raw = 8'h0A;
    for (int i = 0; i < 3; i++) tick();
    bus.swi_raw = 8'h2A;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_quiet("glitch");
      chk("glitch_hold", 32'(bus.swi_stable), 32'h2A);
    end

    // Mixed rise/fall into 0F, then simultaneous 0F -> F0.
    bus.swi_raw = 8'h0F;
    settle("to0f", 8'h2A, 8'h0F, 8'h05, 8'h20);
    bus.swi_raw = 8'hF0;
    settle("simul", 8'h0F, 8'hF0, 8'hF0, 8'h0F);

    // Drop bit 7, then raise it and reset two edges into the count.
    bus.swi_raw = 8'h70;
    settle("drop7", 8'hF0, 8'h70, 8'h00, 8'h80);
    bus.swi_raw = 8'hF0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_quiet("qual7");
    end
    reset = 1'b1;
    tick();
    chk("midrst_stable", 32'(bus.swi_stable), 32'h0);
    chk_quiet("midrst");
    reset = 1'b0;
    settle("midrst_rel", 8'h00, 8'hF0, 8'hF0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/swi_debouncer.md
# swi_debouncer

Input-conditioning stage between the raw board switches `SWI` and the hex counter / display logic in `top`. Each switch bit is synchronised, debounced by a per-bit stability counter, and delivered as a clean level plus one-cycle rise/fall pulses. The counter block consumes the stable levels for its `reset`, `count_up`, `counter_on`, `load` and `data_in` controls. It can use the pulses for edge-triggered load or step actions.

## Interface
- `NBITS`, 8, number of switch bits conditioned (matches `NBITS_TOP`).
- `DEBOUNCE_CYCLES`, 16, consecutive `clk_2` cycles a synchronised input must differ from the stable value before the stable value is updated; legal range 1..65535.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES+1)`, per-bit counter width; derived, never overridden.

Ports:
- `clk_2`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset; sampled only on posedge `clk_2`; dedicated input, never driven from this block's own outputs.
- `swi_raw`  in  NBITS  asynchronous, bouncy switch levels.
- `swi_stable`  out  NBITS  debounced level per bit, registered.
- `swi_rise`  out  NBITS  one-cycle pulse per bit on a debounced 0→1 transition, registered.
- `swi_fall`  out  NBITS  one-cycle pulse per bit on a debounced 1→0 transition, registered.
- `swi_changed`  out  1  registered OR of all `swi_rise | swi_fall` bits.

## Operation
- Per bit `i`, the block has a two-flop synchroniser `s1[i] <= swi_raw[i]`, `s2[i] <= s1[i]`, plus a counter `cnt[i]` of width `CNT_W` and the stable register.
- Each bit is independent. There is no cross-bit interaction except in `swi_changed`.
- Per-bit update at every posedge, when not in reset:
  - If `s2[i] == swi_stable[i]`: `cnt[i] <= 0`, and rise and fall are 0.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`:
    - `swi_stable[i] <= s2[i]`; `cnt[i] <= 0`.
    - `swi_rise[i] <= s2[i]`; `swi_fall[i] <= ~s2[i]`.
  - Else: `cnt[i] <= cnt[i]+1`, and rise and fall are 0.
- Per-bit state is effectively IDLE (`cnt==0`, inputs agree) or QUALIFYING (`cnt>0`).
  - Any return of `s2` to the stable value drops the bit back to IDLE and discards the partial count. A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `swi_stable`.
- Counter arithmetic is unsigned and never exceeds `DEBOUNCE_CYCLES-1`, so no wrap-around is possible.
- `swi_changed <= |(next_rise | next_fall)`, registered so it is aligned with the pulses.
- Reset (synchronous, priority over everything) sets `s1`, `s2`, `swi_stable`, `cnt`, `swi_rise`, `swi_fall` and `swi_changed` all to 0.
- Reset asserted mid-qualification discards the count, and no pulse is emitted in or after the reset cycle.
- A switch held at 1 through reset produces a normal `swi_rise` once reset deasserts, after the full latency.
- Simultaneous transitions on several bits produce simultaneous pulses and a single `swi_changed` pulse.

## Timing
- `swi_raw[i]` changes and stays constant before posedge k. Then:
  - `s1` updates at k and `s2` at k+1.
  - `swi_stable[i]` updates at k+1+`DEBOUNCE_CYCLES`.
  - Total latency is `DEBOUNCE_CYCLES`+2 edges, counting k as edge 1.
- `swi_rise`/`swi_fall`/`swi_changed` are high for exactly the one cycle in which `swi_stable` first shows the new value. They return to 0 at the next posedge.
- Back-to-back qualified changes on one bit are at least `DEBOUNCE_CYCLES` cycles apart, so pulses on a bit are never adjacent when `DEBOUNCE_CYCLES`>1.
- With `DEBOUNCE_CYCLES=1`, latency is 3 edges. Pulses on one bit may then occur in consecutive cycles if the input toggles every cycle.
- No combinational path from any input to any output.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `NBITS=8`.
- Reset: hold `reset=1` for 2 cycles with `swi_raw=8'hFF` -> all outputs 0 during reset. After release, `swi_stable=8'hFF` and `swi_rise=8'hFF` for one cycle, 6 edges after the first non-reset edge, with `swi_changed=1` in that cycle.
- Clean step: `swi_raw[3]` 0→1 before edge k -> `swi_stable[3]=1` and `swi_rise[3]=1` at edge k+5 only. `swi_fall`=0 and other bits are unchanged.
- Bounce: `swi_raw[1]` pattern 1,0,1,1,0 (one value per cycle), then steady 1 -> no pulse during the bounce. A single `swi_rise[1]` arrives exactly 6 edges after the last 0→1 edge.
- Glitch reject: `swi_stable[5]=1`, `swi_raw[5]` low for 3 cycles then high -> `swi_stable[5]` stays 1, and `swi_fall[5]` is never asserted.
- Simultaneous: `swi_raw` 8'h0F→8'hF0 in one cycle -> after latency, `swi_rise=8'hF0`, `swi_fall=8'h0F` and `swi_changed=1`, all for one cycle.
- Reset mid-qualification: `swi_raw[7]` rises, then `reset=1` for 1 cycle at 2 edges into the count -> no pulse. Full 6-edge latency is measured from the reset-release edge, then `swi_rise[7]=1`.
